// File: rtl/piece_drop_ctrl_if.sv
// piece_drop_ctrl_if: request inputs and playfield/status outputs of the drop controller.
// The master side drives requests; the slave side (the controller) drives status.
interface piece_drop_ctrl_if #(
    parameter int ROWS    = 10,
    parameter int COLS    = 10,
    parameter int SCORE_W = 8
);
    logic                 downTrue;
    logic                 move_left;
    logic                 move_right;
    logic                 restart;
    logic [0:ROWS*COLS-1] field;
    logic [3:0]           active_row;
    logic [3:0]           active_col;
    logic [SCORE_W-1:0]   score;
    logic                 piece_spawn;
    logic                 busy;
    logic                 game_over;

    modport master (
        output downTrue, move_left, move_right, restart,
        input  field, active_row, active_col, score, piece_spawn, busy, game_over
    );

    modport slave (
        input  downTrue, move_left, move_right, restart,
        output field, active_row, active_col, score, piece_spawn, busy, game_over
    );
endinterface

// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl: single-cell falling-block controller for a ROWS x COLS playfield.
// Owns the settled map and active cell; handles landing, locking, row clears and game over.
module piece_drop_ctrl #(
    parameter int ROWS      = 10,
    parameter int COLS      = 10,
    parameter int SPAWN_COL = 4,
    parameter int SCORE_W   = 8
) (
    input logic              clock_b,
    input logic              reset_n,
    piece_drop_ctrl_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {SPAWN, FALL, LOCK, CLEAR, GAMEOVER} state_e;

    state_e             state_q, state_d;
    logic [0:N-1]       settled_q, settled_d, active_mask;
    logic [3:0]         row_q, row_d, col_q, col_d, scan_q, scan_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               spawn_q, spawn_d;
    logic [IW-1:0]      cur_idx, below_idx, left_idx, right_idx, scan_base;
    logic               at_bottom, land, can_left, can_right, row_full;

    assign cur_idx   = IW'(row_q) * IW'(COLS) + IW'(col_q);
    assign at_bottom = row_q == 4'(ROWS - 1);
    // Neighbour indices are clamped so no lookup ever leaves the map
    assign below_idx = at_bottom ? cur_idx : cur_idx + IW'(COLS);
    assign left_idx  = (col_q == 4'd0) ? cur_idx : cur_idx - IW'(1);
    assign right_idx = (col_q == 4'(COLS - 1)) ? cur_idx : cur_idx + IW'(1);
    assign land      = at_bottom || settled_q[below_idx];
    assign can_left  = col_q != 4'd0 && !settled_q[left_idx];
    assign can_right = col_q != 4'(COLS - 1) && !settled_q[right_idx];
    assign scan_base = IW'(scan_q) * IW'(COLS);
    assign row_full  = &settled_q[scan_base +: COLS];

    always_comb begin
        active_mask          = '0;
        active_mask[cur_idx] = state_q == FALL;
    end

    always_comb begin
        state_d   = state_q;
        settled_d = settled_q;
        row_d     = row_q;
        col_d     = col_q;
        scan_d    = scan_q;
        score_d   = score_q;
        spawn_d   = 1'b0;
        case (state_q)
            SPAWN: begin
                if (settled_q[SPAWN_COL]) begin
                    state_d = GAMEOVER;
                end else begin
                    row_d   = 4'd0;
                    col_d   = 4'(SPAWN_COL);
                    spawn_d = 1'b1;
                    state_d = FALL;
                end
            end
            FALL: begin
                if (bus.downTrue) begin
                    if (land) state_d = LOCK;
                    else row_d = row_q + 4'd1;
                end else if (bus.move_left && !bus.move_right && can_left) begin
                    col_d = col_q - 4'd1;
                end else if (bus.move_right && !bus.move_left && can_right) begin
                    col_d = col_q + 4'd1;
                end
            end
            LOCK: begin
                settled_d[cur_idx] = 1'b1;
                scan_d             = 4'(ROWS - 1);
                state_d            = CLEAR;
            end
            CLEAR: begin
                // A full row pulls everything above it down one and is rescanned
                if (row_full) begin
                    settled_d[0:COLS-1] = '0;
                    for (int r = 1; r < ROWS; r++)
                        if (r <= int'(scan_q)) settled_d[r*COLS +: COLS] = settled_q[(r-1)*COLS +: COLS];
                    score_d = score_q + SCORE_W'(score_q != '1);
                end else if (scan_q == 4'd0) begin
                    state_d = SPAWN;
                end else begin
                    scan_d = scan_q - 4'd1;
                end
            end
            GAMEOVER: begin
                if (bus.restart) begin
                    settled_d = '0;
                    score_d   = '0;
                    state_d   = SPAWN;
                end
            end
            default: state_d = SPAWN;
        endcase
    end

    always_ff @(posedge clock_b or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SPAWN;
            settled_q <= '0;
            row_q     <= 4'd0;
            col_q     <= 4'(SPAWN_COL);
            scan_q    <= 4'd0;
            score_q   <= '0;
            spawn_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            settled_q <= settled_d;
            row_q     <= row_d;
            col_q     <= col_d;
            scan_q    <= scan_d;
            score_q   <= score_d;
            spawn_q   <= spawn_d;
        end
    end

    assign bus.field       = settled_q | active_mask;
    assign bus.active_row  = row_q;
    assign bus.active_col  = col_q;
    assign bus.score       = score_q;
    assign bus.piece_spawn = spawn_q;
    assign bus.busy        = state_q == LOCK || state_q == CLEAR;
    assign bus.game_over   = state_q == GAMEOVER;
endmodule

// File: tb/tb_piece_drop_ctrl.sv
// tb_piece_drop_ctrl: directed and randomized checks of piece_drop_ctrl against a grid-level model.
module tb_piece_drop_ctrl;
    localparam int ROWS = 10, COLS = 10, SPAWN_COL = 4, SCORE_W = 8, N = ROWS * COLS;

    logic clock_b = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0, errors = 0;

    bit grid [ROWS][COLS];
    int mr, mc, mscore, exp_busy, exp_spawn;
    bit mover, mlanded;

    always #5 clock_b = ~clock_b;

    piece_drop_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) bus ();
    piece_drop_ctrl #(.ROWS(ROWS), .COLS(COLS), .SPAWN_COL(SPAWN_COL), .SCORE_W(SCORE_W)) dut (
        .clock_b(clock_b),
        .reset_n(reset_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Landing removes every full row at once and compacts the rest downward
    function automatic void model_tick();
        bit ng [ROWS][COLS];
        bit full;
        int k, dst;
        mlanded = 0;
        if (mover) return;
        if (mr < ROWS - 1 && !grid[mr+1][mc]) begin
            mr++;
            return;
        end
        mlanded = 1;
        grid[mr][mc] = 1;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) ng[r][c] = 0;
        k = 0;
        dst = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1;
            for (int c = 0; c < COLS; c++) full &= grid[r][c];
            if (full) k++;
            else begin
                for (int c = 0; c < COLS; c++) ng[dst][c] = grid[r][c];
                dst--;
            end
        end
        grid = ng;
        mscore = (mscore + k > (1 << SCORE_W) - 1) ? (1 << SCORE_W) - 1 : mscore + k;
        exp_busy = 1 + ROWS + k;
        if (grid[0][SPAWN_COL]) mover = 1;
        else begin
            mr = 0;
            mc = SPAWN_COL;
            exp_spawn = 1;
        end
    endfunction

    function automatic void model_move(input bit l, input bit r);
        if (mover || l == r) return;
        if (l && mc > 0 && !grid[mr][mc-1]) mc--;
        else if (r && mc < COLS - 1 && !grid[mr][mc+1]) mc++;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) grid[r][c] = 0;
        mscore = 0;
        mover = 0;
        mr = 0;
        mc = SPAWN_COL;
    endfunction

    task automatic check_state(input string tag);
        logic [0:N-1] ef;
        ef = '0;
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) ef[r*COLS+c] = grid[r][c];
        if (!mover) ef[mr*COLS+mc] = 1'b1;
        chk({tag, ".field"}, bus.field, ef);
        chk({tag, ".row"}, bus.active_row, mr);
        chk({tag, ".col"}, bus.active_col, mc);
        chk({tag, ".score"}, bus.score, mscore);
        chk({tag, ".go"}, bus.game_over, mover);
        chk({tag, ".busy"}, bus.busy, 0);
    endtask

    // One request pulse, then a window long enough for lock, full scan and respawn
    task automatic act(input bit d, input bit l, input bit r, input bit rs);
        int wc, nb, ns;
        exp_busy = 0;
        exp_spawn = 0;
        if (rs) begin
            if (mover) begin
                model_clear();
                exp_spawn = 1;
            end
        end else if (d) model_tick();
        else model_move(l, r);
        wc = (exp_busy > 0 || exp_spawn > 0) ? 16 : 2;
        bus.downTrue = d;
        bus.move_left = l;
        bus.move_right = r;
        bus.restart = rs;
        @(negedge clock_b);
        bus.downTrue = 0;
        bus.move_left = 0;
        bus.move_right = 0;
        bus.restart = 0;
        nb = 0;
        ns = 0;
        repeat (wc) begin
            nb += int'(bus.busy);
            ns += int'(bus.piece_spawn);
            @(negedge clock_b);
        end
        chk("act.busy_cycles", nb, exp_busy);
        chk("act.spawn_pulses", ns, exp_spawn);
        check_state("act");
    endtask

    task automatic drop_at(input int c);
        int n;
        n = 0;
        while (!mover && mc != c && n < 20) begin
            act(0, mc > c, mc < c, 0);
            n++;
        end
        mlanded = 0;
        while (!mover && !mlanded && n < 40) begin
            act(1, 0, 0, 0);
            n++;
        end
    endtask

    task automatic do_reset(input bit now);
        int ns;
        bus.downTrue = 0;
        bus.move_left = 0;
        bus.move_right = 0;
        bus.restart = 0;
        if (!now) @(negedge clock_b);
        #2 reset_n = 1'b0;
        #1;
        chk("rst.field", bus.field, 0);
        chk("rst.row", bus.active_row, 0);
        chk("rst.col", bus.active_col, SPAWN_COL);
        chk("rst.score", bus.score, 0);
        chk("rst.spawn", bus.piece_spawn, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.go", bus.game_over, 0);
        model_clear();
        @(negedge clock_b);
        reset_n = 1'b1;
        ns = 0;
        repeat (4) begin
            @(negedge clock_b);
            ns += int'(bus.piece_spawn);
        end
        chk("rst.first_spawn", ns, 1);
        check_state("rst");
    endtask

    initial begin
        logic [0:N-1] exf;
        int pick, n;
        do_reset(0);

        for (int i = 0; i < 9; i++) begin
            act(1, 0, 0, 0);
            repeat (10) @(negedge clock_b);
        end
        chk("descent.row9", bus.active_row, 9);
        exp_busy = 0;
        exp_spawn = 0;
        model_tick();
        bus.downTrue = 1;
        @(negedge clock_b);
        bus.downTrue = 0;
        chk("lock.hidden", bus.field[94], 0);
        @(negedge clock_b);
        chk("lock.visible", bus.field[94], 1);
        repeat (14) @(negedge clock_b);
        check_state("lock");

        act(0, 0, 0, 1);
        repeat (6) act(0, 1, 0, 0);
        chk("left.col0", bus.active_col, 0);
        repeat (11) act(0, 0, 1, 0);
        chk("right.col9", bus.active_col, 9);
        act(0, 1, 1, 0);
        act(1, 1, 0, 0);
        chk("tick_prio.row", bus.active_row, 1);
        chk("tick_prio.col", bus.active_col, 9);

        do_reset(0);
        for (int c = 0; c < COLS; c++) drop_at(c);
        chk("clear.score", bus.score, 1);
        chk("clear.row9", bus.field[90:99], 0);

        do_reset(0);
        for (int c = 0; c < COLS - 1; c++) drop_at(c);
        for (int c = 0; c < COLS - 1; c++) drop_at(c);
        drop_at(0);
        drop_at(COLS - 1);
        drop_at(COLS - 1);
        exf = '0;
        exf[90] = 1'b1;
        exf[SPAWN_COL] = 1'b1;
        chk("dbl.score", bus.score, 2);
        chk("dbl.field", bus.field, exf);

        n = 0;
        while (!(mr == ROWS - 1 || grid[mr+1][mc]) && n < ROWS) begin
            act(1, 0, 0, 0);
            n++;
        end
        bus.downTrue = 1;
        @(negedge clock_b);
        bus.downTrue = 0;
        @(negedge clock_b);
        @(negedge clock_b);
        chk("mid.busy", bus.busy, 1);
        do_reset(1);

        do_reset(0);
        repeat (ROWS) drop_at(SPAWN_COL);
        chk("go.flag", bus.game_over, 1);
        act(1, 0, 0, 0);
        act(0, 1, 0, 0);
        act(0, 0, 0, 1);
        chk("restart.go", bus.game_over, 0);

        do_reset(0);
        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 99);
            if (mover && pick < 40) act(0, 0, 0, 1);
            else if (pick < 15) drop_at($urandom_range(0, COLS - 1));
            else if (pick < 50) act(1, $urandom_range(0, 1), $urandom_range(0, 1), 0);
            else if (pick < 70) act(0, 1, 0, 0);
            else if (pick < 90) act(0, 0, 1, 0);
            else if (pick < 95) act(0, 1, 1, 0);
            else act(0, 0, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
